// File: rtl/draw_sequencer_pkg.sv
// Shared types for the draw sequencer: mode/step state encodings, the
// watchdog default and small helpers that map a step state to its bit index.
package draw_seq_pkg;

  localparam int WDOG_CYCLES_DEFAULT = 20000;
  localparam int NUM_STEPS           = 8;

  typedef enum logic [1:0] {
    MODE_START = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_OVER  = 2'd2
  } mode_t;

  // Draw steps are contiguous so that (step - STEP_SCREEN) is the handshake index.
  typedef enum logic [3:0] {
    STEP_IDLE,
    STEP_LAUNCH,
    STEP_SCREEN,
    STEP_LEVEL,
    STEP_PADDLE,
    STEP_BALL,
    STEP_SCORE,
    STEP_LIFE,
    STEP_BALLCHECK,
    STEP_SCOREUPD
  } step_t;

  typedef enum logic {
    PHASE_RST,
    PHASE_EN
  } phase_t;

  function automatic logic is_draw_step(step_t s);
    return s >= STEP_SCREEN;
  endfunction

  function automatic logic [2:0] step_index(step_t s);
    return 3'(s - STEP_SCREEN);
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Per-step handshake bundle between the sequencer (master) and the draw engines (slave).
interface draw_sequencer_if;

  logic screenDrawEnable, levelDrawEnable, paddleDrawEnable, ballDrawEnable;
  logic scoreDrawEnable, lifeDrawEnable, ballcheckEnable, scoreEnable;
  logic screenDrawReset, levelDrawReset, paddleDrawReset, ballDrawReset;
  logic scoreDrawReset, lifeDrawReset, ballcheckReset;
  logic screenDrawEnd, levelDrawEnd, paddleDrawEnd, ballDrawEnd;
  logic scoreDrawEnd, lifeDrawEnd, ballcheckEnd, scoreEnd;

  modport master (
    output screenDrawEnable, levelDrawEnable, paddleDrawEnable, ballDrawEnable,
           scoreDrawEnable, lifeDrawEnable, ballcheckEnable, scoreEnable,
           screenDrawReset, levelDrawReset, paddleDrawReset, ballDrawReset,
           scoreDrawReset, lifeDrawReset, ballcheckReset,
    input  screenDrawEnd, levelDrawEnd, paddleDrawEnd, ballDrawEnd,
           scoreDrawEnd, lifeDrawEnd, ballcheckEnd, scoreEnd
  );

  modport slave (
    input  screenDrawEnable, levelDrawEnable, paddleDrawEnable, ballDrawEnable,
           scoreDrawEnable, lifeDrawEnable, ballcheckEnable, scoreEnable,
           screenDrawReset, levelDrawReset, paddleDrawReset, ballDrawReset,
           scoreDrawReset, lifeDrawReset, ballcheckReset,
    output screenDrawEnd, levelDrawEnd, paddleDrawEnd, ballDrawEnd,
           scoreDrawEnd, lifeDrawEnd, ballcheckEnd, scoreEnd
  );

endinterface

// File: rtl/draw_sequencer_watchdog.sv
// step_watchdog: counts consecutive enable cycles of one step and flags expiry
// on the WDOG_CYCLES-th cycle; timeout pulses the cycle after a forced finish.
module step_watchdog
  import draw_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic done,
  output logic expire,
  output logic timeout
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      // An End arriving on the expiry cycle counts as a normal finish.
      timeout <= expire && !done;
      if (!run || expire) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: frame-level mode FSM plus per-frame draw step sequencer.
// Define DRAW_SEQ_WATCHDOG_EN to let a stuck step be forced done after WDOG_CYCLES.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic frameTick,
  input  logic startKey,
  input  logic gameRun_internal,
  draw_sequencer_if.master steps,
  output logic drawGameStart,
  output logic drawGameOver,
  output logic frameOverrun,
  output logic stepTimeout
);

  mode_t      mode_q, mode_nxt;
  step_t      step_q, step_nxt;
  phase_t     phase_q, phase_nxt;
  logic [7:0] end_vec, en_q, en_nxt;
  logic [6:0] rst_q, rst_nxt;
  logic [2:0] cur_idx, nxt_idx;
  logic       in_en, cur_end, step_done;
  logic       wd_run, wd_expire, wd_timeout;

  assign end_vec = {steps.scoreEnd, steps.ballcheckEnd, steps.lifeDrawEnd, steps.scoreDrawEnd,
                    steps.ballDrawEnd, steps.paddleDrawEnd, steps.levelDrawEnd, steps.screenDrawEnd};

  assign cur_idx   = step_index(step_q);
  assign in_en     = is_draw_step(step_q) && (phase_q == PHASE_EN);
  assign cur_end   = in_en && end_vec[cur_idx];
  assign step_done = in_en && (end_vec[cur_idx] || wd_expire);

`ifdef DRAW_SEQ_WATCHDOG_EN
  assign wd_run = in_en;
`else
  // Counter never runs, so expire and timeout stay constant zero.
  assign wd_run = 1'b0;
`endif

  step_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (wd_run),
    .done   (cur_end),
    .expire (wd_expire),
    .timeout(wd_timeout)
  );

  assign stepTimeout = wd_timeout;

  always_comb begin
    mode_nxt  = mode_q;
    step_nxt  = step_q;
    phase_nxt = phase_q;
    en_nxt    = '0;
    rst_nxt   = '0;
    nxt_idx   = 3'd0;
    case (step_q)
      STEP_IDLE: begin
        // Mode only changes between frames.
        case (mode_q)
          MODE_START: if (startKey)          mode_nxt = MODE_PLAY;
          MODE_PLAY:  if (!gameRun_internal) mode_nxt = MODE_OVER;
          MODE_OVER:  if (startKey)          mode_nxt = MODE_START;
          default:                           mode_nxt = MODE_START;
        endcase
        if (frameTick) step_nxt = STEP_LAUNCH;
      end
      STEP_LAUNCH: begin
        step_nxt  = STEP_SCREEN;
        phase_nxt = PHASE_RST;
      end
      default: begin
        if (phase_q == PHASE_RST) begin
          phase_nxt = PHASE_EN;
        end else if (step_done) begin
          if (mode_q != MODE_PLAY || step_q == STEP_SCOREUPD) begin
            step_nxt = STEP_IDLE;
          end else begin
            step_nxt  = step_t'(step_q + 4'd1);
            // SCOREUPD has no reset strobe and goes straight to its enable.
            phase_nxt = (step_nxt == STEP_SCOREUPD) ? PHASE_EN : PHASE_RST;
          end
        end
      end
    endcase
    if (is_draw_step(step_nxt)) begin
      nxt_idx = step_index(step_nxt);
      if (phase_nxt == PHASE_EN) begin
        en_nxt[nxt_idx] = 1'b1;
      end else if (nxt_idx != 3'd7) begin
        rst_nxt[nxt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q        <= MODE_START;
      step_q        <= STEP_IDLE;
      phase_q       <= PHASE_RST;
      en_q          <= '0;
      rst_q         <= '0;
      drawGameStart <= 1'b1;
      drawGameOver  <= 1'b0;
      frameOverrun  <= 1'b0;
    end else begin
      mode_q        <= mode_nxt;
      step_q        <= step_nxt;
      phase_q       <= phase_nxt;
      en_q          <= en_nxt;
      rst_q         <= rst_nxt;
      drawGameStart <= (mode_nxt == MODE_START);
      drawGameOver  <= (mode_nxt == MODE_OVER);
      frameOverrun  <= frameTick && (step_q != STEP_IDLE);
    end
  end

  assign steps.screenDrawEnable = en_q[0];
  assign steps.levelDrawEnable  = en_q[1];
  assign steps.paddleDrawEnable = en_q[2];
  assign steps.ballDrawEnable   = en_q[3];
  assign steps.scoreDrawEnable  = en_q[4];
  assign steps.lifeDrawEnable   = en_q[5];
  assign steps.ballcheckEnable  = en_q[6];
  assign steps.scoreEnable      = en_q[7];

  assign steps.screenDrawReset  = rst_q[0];
  assign steps.levelDrawReset   = rst_q[1];
  assign steps.paddleDrawReset  = rst_q[2];
  assign steps.ballDrawReset    = rst_q[3];
  assign steps.scoreDrawReset   = rst_q[4];
  assign steps.lifeDrawReset    = rst_q[5];
  assign steps.ballcheckReset   = rst_q[6];

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 20000, the maximum cycles one draw step may wait for its End.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port frameTick, input, 1, a one-cycle pulse per video frame.
REQ-005 SHALL have port startKey, input, 1, a level-sampled start/restart request.
REQ-006 SHALL have port gameRun_internal, input, 1; a low level means lives are exhausted.
REQ-007 SHALL have ports screenDrawEnd, levelDrawEnd, paddleDrawEnd, ballDrawEnd, scoreDrawEnd, lifeDrawEnd, ballcheckEnd and scoreEnd, each input, 1, the step-done flags.
REQ-008 SHALL have ports screenDrawEnable, levelDrawEnable, paddleDrawEnable, ballDrawEnable, scoreDrawEnable, lifeDrawEnable, ballcheckEnable and scoreEnable, each output, 1, the step enables.
REQ-009 SHALL have ports screenDrawReset, paddleDrawReset, ballDrawReset, levelDrawReset, scoreDrawReset, lifeDrawReset and ballcheckReset, each output, 1, the step-start pulses.
REQ-010 SHALL have ports drawGameStart and drawGameOver, each output, 1, the screen-mode selects.
REQ-011 SHALL have port frameOverrun, output, 1, a one-cycle pulse when a frame tick is dropped.
REQ-012 SHALL have port stepTimeout, output, 1, a one-cycle pulse when the watchdog fires.

Function
REQ-013 Mode FSM SHALL have the states START, PLAY and OVER; START is the reset state.
REQ-014 START SHALL assert drawGameStart; OVER SHALL assert drawGameOver; PLAY SHALL assert neither.
REQ-015 START SHALL move to PLAY, and OVER SHALL move to START, only at a frame boundary (sequencer IDLE) with startKey high.
REQ-016 PLAY SHALL move to OVER at a frame boundary when gameRun_internal is low.
REQ-017 Step FSM SHALL wait in IDLE and start a frame on the cycle after a frameTick sampled in IDLE.
REQ-018 PLAY step order SHALL be SCREEN, LEVEL, PADDLE, BALL, SCORE, LIFE, BALLCHECK, SCOREUPD, then back to IDLE.
REQ-019 START and OVER frames SHALL run the SCREEN step only.
REQ-020 Each step SHALL take one RST cycle, with only its *Reset high, followed by EN cycles with only its *Enable high.
REQ-021 SCOREUPD has no reset port, so it SHALL skip RST.
REQ-022 Enable SHALL stay high until its End is sampled high; it SHALL be low in the next cycle, which is the next step's RST cycle.
REQ-023 At most one *Enable and at most one *Reset SHALL be high in any cycle, and never both together.
REQ-024 An End input sampled outside its own EN phase SHALL be ignored.
REQ-025 A frameTick arriving while the step FSM is not IDLE SHALL be dropped and SHALL pulse frameOverrun on the following cycle.
REQ-026 A frameTick coinciding with the final End SHALL also be dropped.
REQ-027 Mode transitions SHALL never occur mid-frame; a gameRun_internal fall mid-frame SHALL take effect at the next IDLE.
REQ-028 Latency from frameTick to the first *Reset SHALL be 2 cycles.

Reset
REQ-029 reset low at any clock edge SHALL abort any step in progress.
REQ-030 Reset SHALL force mode START and step IDLE.
REQ-031 Reset SHALL drive every Enable and Reset output low.
REQ-032 Reset SHALL force drawGameStart=1, drawGameOver=0, frameOverrun=0 and stepTimeout=0.
REQ-033 Reset SHALL clear the watchdog counter.

Configuration
REQ-034 With DRAW_SEQ_WATCHDOG_EN defined, an EN phase lasting WDOG_CYCLES cycles without its End SHALL force that step done.
REQ-035 When the watchdog fires, stepTimeout SHALL pulse once and the sequence SHALL continue with the next step.
REQ-036 Without DRAW_SEQ_WATCHDOG_EN the sequencer SHALL wait indefinitely, and stepTimeout SHALL be tied to 0.

Structure
REQ-037 A shared package draw_seq_pkg SHALL hold the mode and step state enums plus the WDOG_CYCLES default.
REQ-038 The watchdog SHALL be a sub-module step_watchdog, containing a counter, clear and expire logic.

Verification
REQ-039 Reset release, then frameTick -> START frame: screenDrawReset at cycle +2, then screenDrawEnable until screenDrawEnd, then IDLE, with drawGameStart=1 throughout.
REQ-040 startKey=1 at IDLE, then frameTick -> PLAY frame; all 8 enables fire in the REQ-018 order; each End answered 3 cycles after its enable rises gives a 7*(1+4)+4=39-cycle frame.
REQ-041 frameTick during the BALL step -> frameOverrun pulses once; no second frame starts before the next tick in IDLE.
REQ-042 gameRun_internal dropped during LIFE -> the frame completes; the next frame asserts drawGameOver=1 and runs SCREEN only; startKey then returns to START.
REQ-043 WDOG_CYCLES=16 with DRAW_SEQ_WATCHDOG_EN, and paddleDrawEnd held low -> stepTimeout after 16 enable cycles, then BALL begins; the same test with the macro undefined hangs in PADDLE.
REQ-044 reset low in the middle of LEVEL -> on the next edge all enables go to 0, mode=START and step=IDLE.
